// File: rtl/player_pkg.sv
// Shared types and constants for the player kinematics slice: motion states,
// key-vector bit positions and sprite dimensions.
package player_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    LAND   = 2'd3
  } motion_state_t;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_JUMP  = 2;

  localparam int SPRITE_W = 40;
  localparam int SPRITE_H = 40;

endpackage

// File: rtl/player_vert_kinematics.sv
// Vertical motion of the player: ballistic jump FSM (ground, rise, fall, land)
// holding Y and the vertical speed magnitude, advanced once per frame tick.
module player_vert_kinematics
  import player_pkg::*;
#(
  parameter logic [9:0] GROUND_Y = 10'd400,
  parameter logic [7:0] JUMP_VEL = 8'd12,
  parameter logic [7:0] GRAVITY  = 8'd1,
  parameter logic [7:0] MAX_FALL = 8'd12
) (
  input  logic       frame_Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       jumpReq,
  output logic [9:0] PlayerY,
  output logic [7:0] vy,
  output logic       jumping
);

  motion_state_t state, stateNext;
  logic [9:0]  yNext;
  logic [7:0]  vyNext;
  logic [7:0]  vyRiseDec;
  logic [8:0]  vyFallSum;
  logic [7:0]  vyFall;
  logic [10:0] yFallSum;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    stateNext = state;
    yNext     = PlayerY;
    vyNext    = vy;
    vyRiseDec = (vy > GRAVITY) ? vy - GRAVITY : 8'd0;
    vyFallSum = {1'b0, vy} + {1'b0, GRAVITY};
    vyFall    = (vyFallSum > {1'b0, MAX_FALL}) ? MAX_FALL : vyFallSum[7:0];
    yFallSum  = {1'b0, PlayerY} + {3'b000, vyFall};

    unique case (state)
      GROUND: begin
        if (jumpReq) begin
          stateNext = RISE;
          vyNext    = JUMP_VEL;
        end
      end
      RISE: begin
        // Ceiling clamp: a step larger than the remaining height pins Y to 0.
        if ({2'b00, vy} > PlayerY) begin
          stateNext = FALL;
          yNext     = '0;
          vyNext    = '0;
        end else begin
          yNext  = PlayerY - {2'b00, vy};
          vyNext = vyRiseDec;
          if (vyRiseDec == 8'd0) stateNext = FALL;
        end
      end
      FALL: begin
        if (yFallSum >= {1'b0, GROUND_Y}) begin
          stateNext = LAND;
          yNext     = GROUND_Y;
          vyNext    = '0;
        end else begin
          yNext  = yFallSum[9:0];
          vyNext = vyFall;
        end
      end
      LAND:    stateNext = GROUND;
      default: stateNext = GROUND;
    endcase
  end

  always_ff @(posedge frame_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state   <= GROUND;
      PlayerY <= GROUND_Y;
      vy      <= '0;
      jumping <= 1'b0;
    end else if (tick) begin
      state   <= stateNext;
      PlayerY <= yNext;
      vy      <= vyNext;
      jumping <= (stateNext == RISE) || (stateNext == FALL);
    end
  end

endmodule

// File: rtl/player_jump_motion.sv
// Per-frame player kinematics: horizontal walking with screen clamps, jump
// edge detection, and the vertical jump sub-module. Updates only on frame_tick.
module player_jump_motion
  import player_pkg::*;
#(
  parameter logic [9:0] X_START  = 10'd100,
  parameter logic [9:0] GROUND_Y = 10'd400,
  parameter logic [9:0] X_MAX    = 10'd600,
  parameter logic [9:0] X_STEP   = 10'd2,
  parameter logic [7:0] JUMP_VEL = 8'd12,
  parameter logic [7:0] GRAVITY  = 8'd1,
  parameter logic [7:0] MAX_FALL = 8'd12
) (
  input  logic       frame_Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [3:0] keycode,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic       moving,
  output logic       playerDirection,
  output logic       jumping,
  output logic [7:0] vy
);

  logic        left, right;
  logic        jumpPrev, jumpReq;
  logic [10:0] xSum;
  logic [9:0]  xNext;
  logic        dirNext, movingNext;
  logic        unusedKey;

  assign left      = keycode[KEY_LEFT];
  assign right     = keycode[KEY_RIGHT];
  assign unusedKey = keycode[3];
  // Rising edge of the jump key, sampled tick to tick, so holding never re-triggers.
  assign jumpReq   = keycode[KEY_JUMP] & ~jumpPrev;

  always_comb begin
    xNext      = PlayerX;
    dirNext    = playerDirection;
    movingNext = 1'b0;
    xSum       = {1'b0, PlayerX} + {1'b0, X_STEP};
    if (left && !right) begin
      xNext      = (PlayerX > X_STEP) ? PlayerX - X_STEP : 10'd0;
      dirNext    = 1'b1;
      movingNext = 1'b1;
    end else if (right && !left) begin
      xNext      = (xSum > {1'b0, X_MAX}) ? X_MAX : xSum[9:0];
      dirNext    = 1'b0;
      movingNext = 1'b1;
    end
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      PlayerX         <= X_START;
      moving          <= 1'b0;
      playerDirection <= 1'b0;
      jumpPrev        <= 1'b0;
    end else if (frame_tick) begin
      PlayerX         <= xNext;
      moving          <= movingNext;
      playerDirection <= dirNext;
      jumpPrev        <= keycode[KEY_JUMP];
    end
  end

  player_vert_kinematics #(
    .GROUND_Y (GROUND_Y),
    .JUMP_VEL (JUMP_VEL),
    .GRAVITY  (GRAVITY),
    .MAX_FALL (MAX_FALL)
  ) u_vert (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .tick      (frame_tick),
    .jumpReq   (jumpReq),
    .PlayerY   (PlayerY),
    .vy        (vy),
    .jumping   (jumping)
  );

endmodule

// File: tb/tb_player_jump_motion.sv
// Self-checking bench for player_jump_motion: directed scenarios plus random
// key traffic, compared against a trajectory-queue model of the player.
module tb_player_jump_motion;

  logic       frame_Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] keycode = 4'b0000;
  logic [9:0] PlayerX, PlayerY;
  logic       moving, playerDirection, jumping;
  logic [7:0] vy;

  int checks = 0;
  int errors = 0;

  always #5 frame_Clk = ~frame_Clk;

  player_jump_motion dut (
    .frame_Clk       (frame_Clk),
    .Reset           (Reset),
    .frame_tick      (frame_tick),
    .keycode         (keycode),
    .PlayerX         (PlayerX),
    .PlayerY         (PlayerY),
    .moving          (moving),
    .playerDirection (playerDirection),
    .jumping         (jumping),
    .vy              (vy)
  );

  // Model: X/direction by plain arithmetic; a jump is precomputed as a queue
  // of per-tick (Y, speed, airborne) samples that is consumed one per tick.
  typedef struct {int y; int v; bit j;} vert_t;
  vert_t traj[$];
  int mX, mY, mVy;
  bit mMov, mDir, mJmp, mPrev;

  int riseY[12] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322};

  function automatic logic [30:0] observed();
    return {PlayerX, PlayerY, vy, moving, playerDirection, jumping};
  endfunction

  function automatic logic [30:0] expected();
    return {mX[9:0], mY[9:0], mVy[7:0], mMov, mDir, mJmp};
  endfunction

  function automatic void model_reset();
    mX = 100; mY = 400; mVy = 0;
    mMov = 0; mDir = 0; mJmp = 0; mPrev = 0;
    traj.delete();
  endfunction

  function automatic void build_jump();
    int y, v;
    y = 400; v = 12;
    traj.push_back('{400, 12, 1'b1});
    while (1) begin
      if (v > y) begin traj.push_back('{0, 0, 1'b1}); v = 0; y = 0; break; end
      y = y - v;
      v = (v > 1) ? v - 1 : 0;
      traj.push_back('{y, v, 1'b1});
      if (v == 0) break;
    end
    while (1) begin
      v = (v + 1 > 12) ? 12 : v + 1;
      if (y + v >= 400) begin traj.push_back('{400, 0, 1'b0}); break; end
      y = y + v;
      traj.push_back('{y, v, 1'b1});
    end
    traj.push_back('{400, 0, 1'b0});
  endfunction

  function automatic void model_step(input logic [3:0] k);
    vert_t e;
    bit req;
    if (k[0] && !k[1]) begin
      mX = (mX - 2 < 0) ? 0 : mX - 2; mDir = 1; mMov = 1;
    end else if (k[1] && !k[0]) begin
      mX = (mX + 2 > 600) ? 600 : mX + 2; mDir = 0; mMov = 1;
    end else mMov = 0;
    req = k[2] && !mPrev;
    mPrev = k[2];
    if (traj.size() == 0 && req) build_jump();
    if (traj.size() > 0) begin
      e = traj.pop_front();
      mY = e.y; mVy = e.v; mJmp = e.j;
    end
  endfunction

  task automatic tick_keys(input logic [3:0] k);
    @(negedge frame_Clk);
    keycode = k; frame_tick = 1'b1;
    @(posedge frame_Clk);
    #1 frame_tick = 1'b0;
    model_step(k);
    @(negedge frame_Clk);
  endtask

  task automatic do_reset(input logic withTick);
    @(negedge frame_Clk);
    Reset = 1'b1; frame_tick = withTick; keycode = 4'b0011;
    @(posedge frame_Clk);
    #1 Reset = 1'b0; frame_tick = 1'b0;
    model_reset();
    @(negedge frame_Clk);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if (observed() !== expected()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", observed(), expected());
    end
    for (int i = 0; i < 5; i++) begin
      tick_keys(4'b0000);
      checks++;
      if (PlayerX !== 10'd100 || PlayerY !== 10'd400 || moving !== 1'b0 ||
          playerDirection !== 1'b0 || jumping !== 1'b0 || vy !== 8'd0) begin
        errors++; $display("FAIL idle_tick%0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_walk_left();
    do_reset(1'b0);
    for (int i = 1; i <= 60; i++) begin
      tick_keys(4'b0001);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL walk_left_tick%0d: got %h expected %h", i, observed(), expected());
      end
      if (i == 50) begin
        checks++;
        if (PlayerX !== 10'd0 || playerDirection !== 1'b1 || moving !== 1'b1) begin
          errors++; $display("FAIL walk_left_reach0: got X=%0d dir=%b mov=%b expected X=0 dir=1 mov=1",
                             PlayerX, playerDirection, moving);
        end
      end
    end
    tick_keys(4'b0011);
    checks++;
    if (PlayerX !== 10'd0 || moving !== 1'b0 || playerDirection !== 1'b1) begin
      errors++; $display("FAIL both_keys: got X=%0d mov=%b dir=%b expected X=0 mov=0 dir=1",
                         PlayerX, moving, playerDirection);
    end
  endtask

  task automatic test_jump_profile();
    int airborne;
    do_reset(1'b0);
    tick_keys(4'b0100);
    airborne = jumping ? 1 : 0;
    checks++;
    if (vy !== 8'd12 || PlayerY !== 10'd400 || jumping !== 1'b1) begin
      errors++; $display("FAIL jump_start: got vy=%0d Y=%0d j=%b expected vy=12 Y=400 j=1", vy, PlayerY, jumping);
    end
    for (int i = 0; i < 12; i++) begin
      tick_keys(4'b0000);
      if (jumping) airborne++;
      checks++;
      if (PlayerY !== riseY[i][9:0] || observed() !== expected()) begin
        errors++; $display("FAIL rise_tick%0d: got Y=%0d (%h) expected Y=%0d (%h)",
                           i, PlayerY, observed(), riseY[i], expected());
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick_keys(4'b0000);
      if (jumping) airborne++;
      checks++;
      if (observed() !== expected() || vy > 8'd12) begin
        errors++; $display("FAIL fall_tick%0d: got %h expected %h", i, observed(), expected());
      end
    end
    checks++;
    if (PlayerY !== 10'd400 || vy !== 8'd0 || jumping !== 1'b0) begin
      errors++; $display("FAIL landed: got Y=%0d vy=%0d j=%b expected Y=400 vy=0 j=0", PlayerY, vy, jumping);
    end
    tick_keys(4'b0000);
    checks++;
    if (airborne !== 24) begin
      errors++; $display("FAIL airborne_ticks: got %0d expected 24", airborne);
    end
  endtask

  task automatic test_held_jump();
    int starts;
    bit prevJ;
    do_reset(1'b0);
    starts = 0; prevJ = 0;
    for (int i = 0; i < 40; i++) begin
      tick_keys(4'b0100);
      if (jumping && !prevJ) starts++;
      prevJ = jumping;
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL held_jump_tick%0d: got %h expected %h", i, observed(), expected());
      end
    end
    checks++;
    if (starts !== 1) begin
      errors++; $display("FAIL held_jump_count: got %0d expected 1", starts);
    end
    do_reset(1'b0);
    tick_keys(4'b0100);
    repeat (13) tick_keys(4'b0000);
    tick_keys(4'b0100);
    for (int i = 0; i < 11; i++) begin
      tick_keys(4'b0000);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL repress_fall_tick%0d: got %h expected %h", i, observed(), expected());
      end
    end
    checks++;
    if (PlayerY !== 10'd400 || vy !== 8'd0 || jumping !== 1'b0) begin
      errors++; $display("FAIL repress_ignored: got Y=%0d vy=%0d j=%b expected Y=400 vy=0 j=0", PlayerY, vy, jumping);
    end
    tick_keys(4'b0100);
    checks++;
    if (vy !== 8'd12 || jumping !== 1'b1) begin
      errors++; $display("FAIL repress_ground: got vy=%0d j=%b expected vy=12 j=1", vy, jumping);
    end
  endtask

  task automatic test_right_jump_clamp();
    do_reset(1'b0);
    repeat (245) tick_keys(4'b0010);
    checks++;
    if (PlayerX !== 10'd590) begin
      errors++; $display("FAIL walk_right_590: got %0d expected 590", PlayerX);
    end
    tick_keys(4'b0110);
    for (int i = 0; i < 25; i++) begin
      tick_keys(4'b0110);
      checks++;
      if (observed() !== expected() || (i < 12 && PlayerY !== riseY[i][9:0]) || (i >= 4 && PlayerX !== 10'd600)) begin
        errors++; $display("FAIL right_jump_tick%0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_reset_midjump();
    do_reset(1'b0);
    tick_keys(4'b0101);
    repeat (8) tick_keys(4'b0000);
    checks++;
    if (PlayerY !== 10'd332 || jumping !== 1'b1) begin
      errors++; $display("FAIL midjump_setup: got Y=%0d j=%b expected Y=332 j=1", PlayerY, jumping);
    end
    do_reset(1'b1);
    checks++;
    if (PlayerX !== 10'd100 || PlayerY !== 10'd400 || vy !== 8'd0 || jumping !== 1'b0 ||
        moving !== 1'b0 || playerDirection !== 1'b0) begin
      errors++; $display("FAIL reset_midjump: got %h expected %h", observed(), expected());
    end
    tick_keys(4'b0100);
    checks++;
    if (vy !== 8'd12 || jumping !== 1'b1) begin
      errors++; $display("FAIL jump_after_reset: got vy=%0d j=%b expected vy=12 j=1", vy, jumping);
    end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      tick_keys(4'($urandom_range(0, 15)));
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL random_tick%0d: got %h expected %h", i, observed(), expected());
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge frame_Clk);
        keycode = 4'($urandom_range(0, 15));
      end
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL random_idle%0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_walk_left();
    test_jump_profile();
    test_held_jump();
    test_right_jump_clamp();
    test_reset_midjump();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
